// File: rtl/rf_scoreboard_pkg.sv
// Shared constants and types for the register-file pending-write scoreboard.
package rf_scoreboard_pkg;
    localparam int NUM_REGS     = 8;
    localparam int SEL_W        = 3;
    localparam int CNT_W        = 2;
    localparam int MAX_PEND     = 3;
    localparam int DRAIN_CYCLES = 4;
    localparam int INFL_W       = 5;
    localparam int DRAIN_W      = $clog2(DRAIN_CYCLES) + 1;

    typedef enum logic {RUN, DRAIN} sb_state_e;
    typedef logic [SEL_W-1:0] reg_sel_t;
endpackage

// File: rtl/rf_scoreboard_if.sv
// Decode/writeback/flush bundle between the pipeline and the scoreboard.
interface rf_scoreboard_if;
    import rf_scoreboard_pkg::*;

    logic                 issue_valid;
    reg_sel_t             issue_rs;
    logic                 issue_rs_used;
    reg_sel_t             issue_rt;
    logic                 issue_rt_used;
    logic                 issue_wr_en;
    reg_sel_t             issue_wr_reg;
    logic                 wb_valid;
    reg_sel_t             wb_reg;
    logic                 flush;
    logic                 stall;
    logic                 issue_accept;
    logic [NUM_REGS-1:0]  pend_mask;
    logic [INFL_W-1:0]    inflight;
    logic                 err;

    modport master (
        output issue_valid, issue_rs, issue_rs_used, issue_rt, issue_rt_used,
               issue_wr_en, issue_wr_reg, wb_valid, wb_reg, flush,
        input  stall, issue_accept, pend_mask, inflight, err
    );
    modport slave (
        input  issue_valid, issue_rs, issue_rs_used, issue_rt, issue_rt_used,
               issue_wr_en, issue_wr_reg, wb_valid, wb_reg, flush,
        output stall, issue_accept, pend_mask, inflight, err
    );
endinterface

// File: rtl/rf_scoreboard_sb_counter.sv
// One per-register pending-write counter: saturating up/down with synchronous clear.
module sb_counter
    import rf_scoreboard_pkg::*;
#(
    parameter int W   = CNT_W,
    parameter int MAX = MAX_PEND
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         zero,
    output logic         full
);
    assign zero = (cnt == '0);
    assign full = (cnt == W'(MAX));

    // inc and dec together cancel; ends never wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          cnt <= '0;
        else if (clr)                     cnt <= '0;
        else if (inc && !dec && !full)    cnt <= cnt + 1'b1;
        else if (dec && !inc && !zero)    cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/rf_scoreboard.sv
// Issue-side scoreboard: per-register pending writes, RAW/limit stall, flush drain window.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int NUM_REGS_P     = NUM_REGS,
    parameter int CNT_W_P        = CNT_W,
    parameter int MAX_PEND_P     = MAX_PEND,
    parameter int DRAIN_CYCLES_P = DRAIN_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    rf_scoreboard_if.slave  sb
);
    sb_state_e                          state, state_nxt;
    logic [DRAIN_W-1:0]                 dcnt, dcnt_nxt;
    logic [NUM_REGS_P-1:0][CNT_W_P-1:0] cnt;
    logic [NUM_REGS_P-1:0]              zero, full, inc, dec;
    logic                               run, haz, err_set;

    assign run = (state == RUN);

    // hazard sees only this cycle's counts; a same-cycle writeback does not bypass
    assign haz = (sb.issue_rs_used && !zero[sb.issue_rs])
              || (sb.issue_rt_used && !zero[sb.issue_rt])
              || (sb.issue_wr_en   &&  full[sb.issue_wr_reg]);

    assign sb.stall        = sb.issue_valid && (!run || haz);
    assign sb.issue_accept = sb.issue_valid && !sb.stall;

    always_comb begin
        inc = '0;
        dec = '0;
        if (run && !sb.flush) begin
            if (sb.issue_accept && sb.issue_wr_en) inc[sb.issue_wr_reg] = 1'b1;
            if (sb.wb_valid)                        dec[sb.wb_reg]       = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REGS_P; i++) begin : g_cnt
        sb_counter #(.W(CNT_W_P), .MAX(MAX_PEND_P)) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc[i]),
            .dec  (dec[i]),
            .clr  (sb.flush),
            .cnt  (cnt[i]),
            .zero (zero[i]),
            .full (full[i])
        );
    end

    assign sb.pend_mask = ~zero;

    always_comb begin
        sb.inflight = '0;
        for (int i = 0; i < NUM_REGS_P; i++)
            sb.inflight = sb.inflight + INFL_W'(cnt[i]);
    end

    // underflow is benign when a same-register issue lands in the same cycle
    assign err_set = run && !sb.flush && sb.wb_valid && zero[sb.wb_reg] && !inc[sb.wb_reg];

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        if (sb.flush) begin
            state_nxt = DRAIN;
            dcnt_nxt  = DRAIN_W'(DRAIN_CYCLES_P - 1);
        end else if (state == DRAIN) begin
            if (dcnt == '0) state_nxt = RUN;
            else            dcnt_nxt  = dcnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            dcnt   <= '0;
            sb.err <= 1'b0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            if (err_set) sb.err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_scoreboard.sv
// Randomized + directed bench for rf_scoreboard against a count-array reference model.
module tb_rf_scoreboard;
    import rf_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_scoreboard_if sb ();
    rf_scoreboard dut (.clk(clk), .rst(rst), .sb(sb));

    int checks = 0;
    int errors = 0;

    // reference state: plain counts, remaining drain cycles, sticky error
    int cnt_m [NUM_REGS];
    int drain_left;
    bit err_m;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_stall();
        if (!sb.issue_valid) return 1'b0;
        if (drain_left > 0)  return 1'b1;
        return (sb.issue_rs_used && cnt_m[sb.issue_rs] != 0)
            || (sb.issue_rt_used && cnt_m[sb.issue_rt] != 0)
            || (sb.issue_wr_en   && cnt_m[sb.issue_wr_reg] == MAX_PEND);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) cnt_m[i] = 0;
        drain_left = 0;
        err_m = 1'b0;
    endtask

    task automatic model_step();
        bit acc;
        int d;
        acc = sb.issue_valid && !m_stall();
        if (sb.flush) begin
            for (int i = 0; i < NUM_REGS; i++) cnt_m[i] = 0;
            drain_left = DRAIN_CYCLES;
        end else if (drain_left > 0) begin
            drain_left--;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                d = 0;
                if (acc && sb.issue_wr_en && sb.issue_wr_reg == i) d++;
                if (sb.wb_valid && sb.wb_reg == i) d--;
                if (d < 0 && cnt_m[i] == 0) err_m = 1'b1;
                else cnt_m[i] += d;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // every-cycle comparison against the model
    initial begin
        int exp_mask, exp_sum;
        bit s;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_mask = 0;
                exp_sum  = 0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (cnt_m[i] != 0) exp_mask |= (1 << i);
                    exp_sum += cnt_m[i];
                end
                s = m_stall();
                check("stall",     int'(sb.stall), int'(s));
                check("accept",    int'(sb.issue_accept), int'(sb.issue_valid && !s));
                check("pend_mask", int'(sb.pend_mask), exp_mask);
                check("inflight",  int'(sb.inflight), exp_sum);
                check("err",       int'(sb.err), int'(err_m));
            end
        end
    end

    task automatic idle();
        sb.issue_valid = 0; sb.issue_rs = '0; sb.issue_rs_used = 0;
        sb.issue_rt = '0; sb.issue_rt_used = 0; sb.issue_wr_en = 0;
        sb.issue_wr_reg = '0; sb.wb_valid = 0; sb.wb_reg = '0; sb.flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input int r);
        idle();
        sb.issue_valid = 1; sb.issue_wr_en = 1; sb.issue_wr_reg = reg_sel_t'(r);
    endtask

    task automatic wb(input int r);
        sb.wb_valid = 1; sb.wb_reg = reg_sel_t'(r);
    endtask

    initial begin
        idle();
        tick(); tick();
        rst = 0;
        @(negedge clk);
        check("rst_stall", int'(sb.stall), 0);
        check("rst_pend",  int'(sb.pend_mask), 0);
        check("rst_infl",  int'(sb.inflight), 0);
        check("rst_err",   int'(sb.err), 0);
        tick();

        // RAW on R3, no writeback bypass
        issue_wr(3);
        @(negedge clk); check("raw_acc_wr", int'(sb.issue_accept), 1);
        tick();
        idle(); sb.issue_valid = 1; sb.issue_rs = 3'd3; sb.issue_rs_used = 1;
        @(negedge clk); check("raw_stall", int'(sb.stall), 1);
        check("raw_pend", int'(sb.pend_mask), 8);
        tick();
        wb(3);
        @(negedge clk); check("raw_nobypass", int'(sb.stall), 1);
        tick();
        sb.wb_valid = 0;
        @(negedge clk); check("raw_release", int'(sb.stall), 0);
        check("raw_pend0", int'(sb.pend_mask), 0);
        tick();

        // per-register limit on R5
        for (int k = 0; k < 3; k++) begin issue_wr(5); tick(); end
        issue_wr(5);
        @(negedge clk); check("lim_stall", int'(sb.stall), 1);
        check("lim_infl", int'(sb.inflight), 3);
        check("model_cnt5", cnt_m[5], 3);
        tick();
        wb(5);
        @(negedge clk); check("lim_stall_wb", int'(sb.stall), 1);
        tick();
        sb.wb_valid = 0;
        @(negedge clk); check("lim_accept", int'(sb.issue_accept), 1);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin wb(5); tick(); end
        idle();

        // same-cycle issue + wb on R2
        issue_wr(2); tick();
        issue_wr(2); wb(2);
        @(negedge clk); check("net_accept", int'(sb.issue_accept), 1);
        tick();
        idle();
        @(negedge clk); check("net_infl", int'(sb.inflight), 1);
        check("net_pend", int'(sb.pend_mask), 4);
        check("net_err", int'(sb.err), 0);
        tick();
        wb(2); tick(); idle();

        // underflow on R6
        wb(6); tick(); idle();
        @(negedge clk); check("uf_err", int'(sb.err), 1);
        check("uf_pend", int'(sb.pend_mask), 0);
        tick(); tick(); tick();
        @(negedge clk); check("uf_sticky", int'(sb.err), 1);
        tick();
        rst = 1; tick(); rst = 0;
        @(negedge clk); check("uf_rst_clr", int'(sb.err), 0);
        tick();

        // flush and drain window
        issue_wr(1); tick(); issue_wr(4); tick();
        idle(); sb.flush = 1;
        @(negedge clk); check("fl_pend_pre", int'(sb.pend_mask), 18);
        tick();
        issue_wr(0); wb(1);
        for (int k = 0; k < DRAIN_CYCLES; k++) begin
            @(negedge clk); check("fl_stall", int'(sb.stall), 1);
            check("fl_pend", int'(sb.pend_mask), 0);
            tick();
            sb.wb_valid = 0;
        end
        @(negedge clk); check("fl_resume", int'(sb.issue_accept), 1);
        check("fl_err", int'(sb.err), 0);
        tick();
        idle(); wb(0); tick(); idle();

        // async reset with counts pending, then mid-drain
        issue_wr(1); tick(); issue_wr(2); tick(); idle();
        rst = 1; #1;
        check("ar_infl", int'(sb.inflight), 0);
        check("ar_pend", int'(sb.pend_mask), 0);
        tick(); rst = 0; tick();
        issue_wr(7); tick();
        idle(); sb.flush = 1; tick();
        issue_wr(0); tick();
        @(negedge clk); check("ar_drain_stall", int'(sb.stall), 1);
        tick();
        rst = 1; #1;
        check("ar_drain_stall0", int'(sb.stall), 0);
        check("ar_drain_infl", int'(sb.inflight), 0);
        check("ar_drain_err", int'(sb.err), 0);
        tick();
        rst = 0;
        @(negedge clk); check("ar_first_acc", int'(sb.issue_accept), 1);
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            sb.issue_valid   = ($urandom_range(0, 9) < 7);
            sb.issue_rs      = reg_sel_t'($urandom_range(0, 7));
            sb.issue_rs_used = $urandom_range(0, 1);
            sb.issue_rt      = reg_sel_t'($urandom_range(0, 7));
            sb.issue_rt_used = ($urandom_range(0, 3) == 0);
            sb.issue_wr_en   = ($urandom_range(0, 3) != 0);
            sb.issue_wr_reg  = reg_sel_t'($urandom_range(0, 3));
            sb.wb_valid      = ($urandom_range(0, 9) < 5);
            sb.wb_reg        = reg_sel_t'($urandom_range(0, 4));
            sb.flush         = ($urandom_range(0, 49) == 0);
            if (n % 700 == 699) begin rst = 1; #1; tick(); rst = 0; end
            tick();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
